debug_commit_tracker: RTL and testbench

- Producer side of the simulation debug/commit interface.
- Sits at the core's writeback stage and accepts one retire record per handshake.
- Buffers records in a small FIFO and presents them in order on the debug_* port consumed by the simulation monitor.
- Detects the halt instruction, stops intake after it, drains, then reports halted. Maintains a retired-instruction counter.

---
 rtl/debug_commit_tracker.sv | 126 ++++++++++++
 tb/tb_debug_commit_tracker.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_commit_tracker.sv
// Writeback-side producer for the simulation debug/commit port: buffers retire
// records in order, stops intake after the halt instruction, drains, then reports halted.
module debug_commit_tracker #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] HALT_INST = 32'h00100073
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_inst,
  input  logic        wb_regWen,
  input  logic [4:0]  wb_regWaddr,
  input  logic [31:0] wb_regWdata,
  input  logic        debug_ready,
  output logic        debug_valid,
  output logic        debug_halt,
  output logic [31:0] debug_pc,
  output logic        debug_regWen,
  output logic [4:0]  debug_regWaddr,
  output logic [31:0] debug_regWdata,
  output logic        halted,
  output logic [63:0] instret,
  output logic [1:0]  fsm_state
);

  localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] wdata_mem [DEPTH];
  logic [4:0]  waddr_mem [DEPTH];
  logic        wen_mem   [DEPTH];
  logic        halt_mem  [DEPTH];

  logic push;
  logic pop;
  logic push_halt;
  logic head_halt;

  // Handshake contract: a record moves on wb_* when wb_valid && wb_ready at a
  // rising clock edge, and on debug_* when debug_valid && debug_ready; a valid
  // side never waits for ready, and neither side drops its offer until taken.
  // Readiness ignores a same-cycle pop, so a full FIFO costs the producer one cycle.
  assign wb_ready  = reset && (state == ST_RUN) && (count < FULL_COUNT);
  assign push      = wb_valid && wb_ready;
  assign pop       = debug_valid && debug_ready;
  assign push_halt = (wb_inst == HALT_INST);
  assign head_halt = halt_mem[rd_ptr];

  assign debug_valid    = (count != '0);
  assign debug_halt     = debug_valid && head_halt;
  assign debug_pc       = debug_valid ? pc_mem[rd_ptr]    : 32'd0;
  assign debug_regWen   = debug_valid && wen_mem[rd_ptr];
  assign debug_regWaddr = debug_valid ? waddr_mem[rd_ptr] : 5'd0;
  assign debug_regWdata = debug_valid ? wdata_mem[rd_ptr] : 32'd0;
  assign fsm_state      = state;

  // Storage carries no reset: the count gates every read.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[wr_ptr]    <= wb_pc;
      wdata_mem[wr_ptr] <= wb_regWdata;
      waddr_mem[wr_ptr] <= wb_regWaddr;
      wen_mem[wr_ptr]   <= wb_regWen && (wb_regWaddr != 5'd0);
      halt_mem[wr_ptr]  <= push_halt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_RUN;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      halted  <= 1'b0;
      instret <= 64'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        instret <= instret + 64'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case (state)
        ST_RUN: begin
          if (push && push_halt) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pop && head_halt) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
          end
        end
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_RUN;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clock) disable iff (!reset)
    !(push && count == FULL_COUNT));
  a_no_pop_empty: assert property (@(posedge clock) disable iff (!reset)
    !(pop && count == '0));
  a_push_in_run:  assert property (@(posedge clock) disable iff (!reset)
    !(push && state != ST_RUN));
`endif

endmodule

// File: tb/tb_debug_commit_tracker.sv
// Directed bench for debug_commit_tracker: one task per scenario, expected
// values computed by hand or by a small in-order queue model.
module tb_debug_commit_tracker;

  logic        clock;
  logic        reset;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_pc;
  logic [31:0] wb_inst;
  logic        wb_regWen;
  logic [4:0]  wb_regWaddr;
  logic [31:0] wb_regWdata;
  logic        debug_ready;
  logic        debug_valid;
  logic        debug_halt;
  logic [31:0] debug_pc;
  logic        debug_regWen;
  logic [4:0]  debug_regWaddr;
  logic [31:0] debug_regWdata;
  logic        halted;
  logic [63:0] instret;
  logic [1:0]  fsm_state;

  int total;
  int bad;
  logic [31:0] exp_q[$];

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] HALT = 32'h00100073;

  debug_commit_tracker #(.DEPTH(4), .HALT_INST(HALT)) dut (
    .clock(clock), .reset(reset),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pc(wb_pc), .wb_inst(wb_inst),
    .wb_regWen(wb_regWen), .wb_regWaddr(wb_regWaddr), .wb_regWdata(wb_regWdata),
    .debug_ready(debug_ready), .debug_valid(debug_valid), .debug_halt(debug_halt),
    .debug_pc(debug_pc), .debug_regWen(debug_regWen), .debug_regWaddr(debug_regWaddr),
    .debug_regWdata(debug_regWdata), .halted(halted), .instret(instret),
    .fsm_state(fsm_state)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within 200000 time units");
    $fatal(1, "watchdog");
  end

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic wen, input logic [4:0] waddr, input logic [31:0] wdata);
    wb_valid    = v;
    wb_pc       = pc;
    wb_inst     = inst;
    wb_regWen   = wen;
    wb_regWaddr = waddr;
    wb_regWdata = wdata;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    debug_ready = 1'b1;
    drive(1'b1, 32'h80000000, NOP, 1'b1, 5'd5, 32'h1234);
    step(); step();
    total++; if (wb_ready !== 1'b0) begin bad++; $display("FAIL reset_wb_ready got=%0b want=0", wb_ready); end
    total++; if (debug_valid !== 1'b0) begin bad++; $display("FAIL reset_debug_valid got=%0b want=0", debug_valid); end
    total++; if (debug_pc !== 32'd0) begin bad++; $display("FAIL reset_debug_pc got=%h want=0", debug_pc); end
    total++; if (instret !== 64'd0) begin bad++; $display("FAIL reset_instret got=%0d want=0", instret); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%0b want=0", halted); end
    total++; if (fsm_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", fsm_state); end
    reset = 1'b1;
    #1;
  endtask

  task automatic test_first_record();
    total++; if (wb_ready !== 1'b1) begin bad++; $display("FAIL first_wb_ready got=%0b want=1", wb_ready); end
    step();
    drive(1'b0, 32'd0, NOP, 1'b0, 5'd0, 32'd0);
    #1;
    total++; if (debug_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%0b want=1", debug_valid); end
    total++; if (debug_pc !== 32'h80000000) begin bad++; $display("FAIL first_pc got=%h want=80000000", debug_pc); end
    total++; if (debug_regWen !== 1'b1) begin bad++; $display("FAIL first_wen got=%0b want=1", debug_regWen); end
    total++; if (debug_regWaddr !== 5'd5) begin bad++; $display("FAIL first_waddr got=%0d want=5", debug_regWaddr); end
    total++; if (debug_regWdata !== 32'h1234) begin bad++; $display("FAIL first_wdata got=%h want=1234", debug_regWdata); end
    total++; if (debug_halt !== 1'b0) begin bad++; $display("FAIL first_halt got=%0b want=0", debug_halt); end
    step();
    total++; if (instret !== 64'd1) begin bad++; $display("FAIL first_instret got=%0d want=1", instret); end
    total++; if (debug_valid !== 1'b0) begin bad++; $display("FAIL first_empty got=%0b want=0", debug_valid); end
  endtask

  task automatic test_x0_write();
    drive(1'b1, 32'h80000004, NOP, 1'b1, 5'd0, 32'hFFFFFFFF);
    step();
    drive(1'b0, 32'd0, NOP, 1'b0, 5'd0, 32'd0);
    #1;
    total++; if (debug_valid !== 1'b1) begin bad++; $display("FAIL x0_valid got=%0b want=1", debug_valid); end
    total++; if (debug_regWen !== 1'b0) begin bad++; $display("FAIL x0_wen got=%0b want=0", debug_regWen); end
    total++; if (debug_regWdata !== 32'hFFFFFFFF) begin bad++; $display("FAIL x0_wdata got=%h want=ffffffff", debug_regWdata); end
    step();
    total++; if (instret !== 64'd2) begin bad++; $display("FAIL x0_instret got=%0d want=2", instret); end
  endtask

  task automatic test_full();
    int accepted;
    logic ready5;
    accepted = 0;
    ready5 = 1'b1;
    debug_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), NOP, 1'b1, 5'd1, 32'(i));
      #1;
      if (wb_ready === 1'b1) accepted++;
      if (i == 4) ready5 = wb_ready;
      step();
    end
    drive(1'b0, 32'd0, NOP, 1'b0, 5'd0, 32'd0);
    total++; if (accepted != 4) begin bad++; $display("FAIL full_accepted got=%0d want=4", accepted); end
    total++; if (ready5 !== 1'b0) begin bad++; $display("FAIL full_ready5 got=%0b want=0", ready5); end
    debug_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (debug_valid !== 1'b1 || debug_pc !== 32'h200 + 32'(4 * i)) begin
        bad++; $display("FAIL full_order%0d got valid=%0b pc=%h want valid=1 pc=%h", i, debug_valid, debug_pc, 32'h200 + 32'(4 * i));
      end
      step();
    end
    total++; if (debug_valid !== 1'b0) begin bad++; $display("FAIL full_drained got=%0b want=0", debug_valid); end
    total++; if (instret !== 64'd6) begin bad++; $display("FAIL full_instret got=%0d want=6", instret); end
  endtask

  task automatic test_back_to_back();
    int pushes;
    int pops;
    logic [31:0] want;
    logic [63:0] base;
    pushes = 0;
    pops = 0;
    base = instret;
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 32'h1000 + 32'(4 * i), NOP, 1'b1, 5'd3, 32'(i));
      debug_ready = (i % 2 == 0);
      #1;
      if (wb_ready === 1'b1) begin exp_q.push_back(wb_pc); pushes++; end
      if (debug_valid === 1'b1 && debug_ready) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        pops++;
        total++; if (debug_pc !== want) begin bad++; $display("FAIL alt_pc got=%h want=%h", debug_pc, want); end
      end
      step();
    end
    drive(1'b0, 32'd0, NOP, 1'b0, 5'd0, 32'd0);
    debug_ready = 1'b1;
    #1;
    for (int n = 0; n < 20 && debug_valid === 1'b1; n++) begin
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      pops++;
      total++; if (debug_pc !== want) begin bad++; $display("FAIL alt_drain_pc got=%h want=%h", debug_pc, want); end
      step();
    end
    total++; if (pushes != 9) begin bad++; $display("FAIL alt_pushes got=%0d want=9", pushes); end
    total++; if (exp_q.size() != 0 || debug_valid !== 1'b0) begin bad++; $display("FAIL alt_leftover got=%0d valid=%0b want=0", exp_q.size(), debug_valid); end
    total++; if (instret - base !== 64'(pops)) begin bad++; $display("FAIL alt_instret_delta got=%0d want=%0d", instret - base, pops); end
    total++; if (instret !== 64'd15) begin bad++; $display("FAIL alt_instret got=%0d want=15", instret); end
  endtask

  task automatic test_halt();
    logic [31:0] pcs [3];
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
    debug_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pcs[i], (i == 2) ? HALT : NOP, 1'b0, 5'd0, 32'd0);
      step();
    end
    drive(1'b1, 32'h10c, NOP, 1'b1, 5'd7, 32'h77);
    #1;
    total++; if (wb_ready !== 1'b0) begin bad++; $display("FAIL halt_stall got=%0b want=0", wb_ready); end
    total++; if (fsm_state !== 2'd1) begin bad++; $display("FAIL halt_drain_state got=%0d want=1", fsm_state); end
    debug_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (debug_pc !== pcs[i] || debug_halt !== (i == 2) || halted !== 1'b0) begin
        bad++; $display("FAIL halt_out%0d got pc=%h halt=%0b halted=%0b want pc=%h halt=%0b halted=0", i, debug_pc, debug_halt, halted, pcs[i], (i == 2));
      end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (halted !== 1'b1 || debug_valid !== 1'b0 || wb_ready !== 1'b0 || fsm_state !== 2'd2) begin
        bad++; $display("FAIL halt_sticky%0d got halted=%0b valid=%0b ready=%0b state=%0d want 1/0/0/2", i, halted, debug_valid, wb_ready, fsm_state);
      end
      step();
    end
    total++; if (instret !== 64'd18) begin bad++; $display("FAIL halt_instret got=%0d want=18", instret); end
  endtask

  task automatic test_async_reset();
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    total++; if (halted !== 1'b0 || instret !== 64'd0) begin bad++; $display("FAIL areset_halt got halted=%0b instret=%0d want 0/0", halted, instret); end
    step();
    reset = 1'b1;
    debug_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h500 + 32'(4 * i), NOP, 1'b1, 5'd9, 32'(i));
      step();
    end
    drive(1'b0, 32'd0, NOP, 1'b0, 5'd0, 32'd0);
    total++; if (debug_valid !== 1'b1 || debug_pc !== 32'h500) begin bad++; $display("FAIL areset_buffered got valid=%0b pc=%h want 1/500", debug_valid, debug_pc); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (debug_valid !== 1'b0 || instret !== 64'd0 || debug_pc !== 32'd0) begin bad++; $display("FAIL areset_flush got valid=%0b instret=%0d pc=%h want 0/0/0", debug_valid, instret, debug_pc); end
    step();
    reset = 1'b1;
    debug_ready = 1'b1;
    drive(1'b1, 32'h600, NOP, 1'b1, 5'd2, 32'h66);
    step();
    drive(1'b0, 32'd0, NOP, 1'b0, 5'd0, 32'd0);
    #1;
    total++; if (debug_valid !== 1'b1 || debug_pc !== 32'h600) begin bad++; $display("FAIL areset_new got valid=%0b pc=%h want 1/600", debug_valid, debug_pc); end
    step();
    total++; if (debug_valid !== 1'b0 || instret !== 64'd1) begin bad++; $display("FAIL areset_after got valid=%0b instret=%0d want 0/1", debug_valid, instret); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_first_record();
    test_x0_write();
    test_full();
    test_back_to_back();
    test_halt();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
